// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   - ctrl_state_e : FSM state encodings (RUN / SYNC_DRAIN / MEM_WAIT)
//   - REG_ZERO     : architectural $zero register id (never a real hazard)
//   - ctrl_out_t   : bundle of every stall/bubble line driven to the pipeline
//                    registers, plus the fixed patterns the controller emits.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_SYNC_DRAIN = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } ctrl_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Bit order (MSB first) is the order the pipeline registers appear in.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_bubble;
      logic id_ex_stall;
      logic id_ex_bubble;
      logic ex_mem_stall;
      logic ex_mem_bubble;
      logic mem_wb_bubble;
   } ctrl_out_t;

   // Nothing held, nothing flushed.
   localparam ctrl_out_t CO_NONE     = ctrl_out_t'(8'b0000_0000);
   // In reset every register is flushed and nothing is held.
   localparam ctrl_out_t CO_RESET    = ctrl_out_t'(8'b0010_1011);
   // Data memory busy: freeze everything up to EX/MEM, feed WB a bubble.
   localparam ctrl_out_t CO_MEM_WAIT = ctrl_out_t'(8'b1101_0101);
   // Taken branch/jump resolved in EX: kill the two younger instructions.
   localparam ctrl_out_t CO_REDIRECT = ctrl_out_t'(8'b0010_1000);
   // Hold the instruction in ID and let a bubble enter EX.
   localparam ctrl_out_t CO_HOLD_ID  = ctrl_out_t'(8'b1100_1000);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and the hazard controller.
//   Pipeline -> controller : ID operand info, EX load/redirect info,
//                            MEM request/ack handshake.
//   Controller -> pipeline : per-register stall and bubble strobes.
// Modports:
//   master : the pipeline datapath (drives stage info, samples stall/bubble)
//   slave  : the hazard controller
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;

   // ID stage
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_is_sync;
   // EX stage
   logic       ex_mem_to_reg;
   logic [4:0] ex_reg_dst_id;
   logic       ex_redirect;
   // MEM stage handshake
   logic       mem_req;
   logic       mem_ack;
   // Pipeline register controls
   logic       pc_stall;
   logic       if_id_stall;
   logic       if_id_bubble;
   logic       id_ex_stall;
   logic       id_ex_bubble;
   logic       ex_mem_stall;
   logic       ex_mem_bubble;
   logic       mem_wb_bubble;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_sync,
      output ex_mem_to_reg, ex_reg_dst_id, ex_redirect,
      output mem_req, mem_ack,
      input  pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble,
      input  ex_mem_stall, ex_mem_bubble, mem_wb_bubble
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_sync,
      input  ex_mem_to_reg, ex_reg_dst_id, ex_redirect,
      input  mem_req, mem_ack,
      output pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble,
      output ex_mem_stall, ex_mem_bubble, mem_wb_bubble
   );

endinterface

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags the case where the
// instruction in ID reads a register that the load currently in EX will
// write, which the forwarding network cannot cover without one bubble.
// Ports:
//   id_valid                 in  ID holds a real instruction
//   id_rs, id_rt             in  source register ids in ID
//   id_uses_rs, id_uses_rt   in  ID really reads rs / rt
//   ex_mem_to_reg            in  EX instruction is a load
//   ex_reg_dst_id            in  EX destination register
//   load_use                 out hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       ex_mem_to_reg,
   input  logic [4:0] ex_reg_dst_id,
   output logic       load_use
);

   logic [1:0][4:0] src_id;
   logic [1:0]      src_used;
   logic [1:0]      src_hit;

   assign src_id   = {id_rt, id_rs};
   assign src_used = {id_uses_rt, id_uses_rs};

   // One comparator per source operand; an operand that the instruction
   // does not read must never create a hazard even if its field matches.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_used[gi] && (src_id[gi] == ex_reg_dst_id);
      end
   endgenerate

   // Writes to $zero are discarded, so they never produce a dependency.
   assign load_use = id_valid && ex_mem_to_reg &&
                     (ex_reg_dst_id != REG_ZERO) && (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/bubble sequencer for the 5-stage MIPS pipeline. Resolves
// (highest priority first): data-memory waits, EX-resolved redirects,
// load-use hazards and `sync` drain. Also keeps stall/flush performance
// counters and a sticky memory-timeout flag.
// Parameters:
//   SYNC_DRAIN_CYCLES  cycles ID holds a `sync` (1..15)
//   MEM_TIMEOUT        consecutive memory-wait cycles before mem_timeout_err
//   CNT_W              performance counter width
// Ports:
//   sys_clk            in  clock
//   rst_n              in  synchronous active-low reset
//   pipe               slave side of pipeline_hazard_ctrl_if
//   mem_timeout_err    out sticky memory-timeout flag
//   stall_cycles       out cycles with pc_stall asserted (wraps)
//   flush_count        out redirects honoured (wraps)
//   ctrl_state         out FSM state for debug
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT       = 1024,
   parameter int unsigned CNT_W             = 32
)(
   input  logic                 sys_clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave pipe,
   output logic                 mem_timeout_err,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count,
   output logic [1:0]           ctrl_state
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   // The cycle that recognises the sync is itself the first hold cycle, so
   // the counter only has to cover the remaining ones.
   localparam logic [3:0] DRAIN_LOAD = 4'(SYNC_DRAIN_CYCLES - 1);

   ctrl_state_e       state_reg, state_next;
   ctrl_state_e       eff_state;
   logic              ret_sync_reg, ret_sync_next;
   logic [3:0]        drain_cnt_reg, drain_cnt_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              err_reg, err_next;
   logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

   logic      mw;
   logic      redirect;
   logic      load_use;
   logic      draining;
   logic      sync_entry;
   ctrl_out_t co;

   // --------------------------------------------------------------------
   // Hazard qualifiers
   // --------------------------------------------------------------------
   hazard_detect u_hazard_detect (
      .id_valid      (pipe.id_valid),
      .id_rs         (pipe.id_rs),
      .id_rt         (pipe.id_rt),
      .id_uses_rs    (pipe.id_uses_rs),
      .id_uses_rt    (pipe.id_uses_rt),
      .ex_mem_to_reg (pipe.ex_mem_to_reg),
      .ex_reg_dst_id (pipe.ex_reg_dst_id),
      .load_use      (load_use)
   );

   assign mw = pipe.mem_req && !pipe.mem_ack;

   // A redirect seen during a memory wait stays parked in the frozen EX
   // stage and is acted on the cycle the wait ends.
   assign redirect = pipe.ex_redirect && !mw;

   // Once a wait ends, the controller behaves as the state it came from,
   // already in that same cycle.
   assign eff_state = (state_reg == ST_MEM_WAIT) ?
                      (ret_sync_reg ? ST_SYNC_DRAIN : ST_RUN) : state_reg;

   assign draining   = (eff_state == ST_SYNC_DRAIN) && (drain_cnt_reg != 4'd0);
   assign sync_entry = (eff_state == ST_RUN) && pipe.id_valid && pipe.id_is_sync;

   // --------------------------------------------------------------------
   // FSM process 1: state and counter registers
   // --------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_reg     <= ST_RUN;
         ret_sync_reg  <= 1'b0;
         drain_cnt_reg <= '0;
         wait_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         ret_sync_reg  <= ret_sync_next;
         drain_cnt_reg <= drain_cnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         err_reg       <= err_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   // --------------------------------------------------------------------
   // FSM process 2: next-state logic
   // --------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      ret_sync_next  = ret_sync_reg;
      drain_cnt_next = drain_cnt_reg;

      if (mw) begin
         state_next = ST_MEM_WAIT;
         // Only the first wait cycle knows where we came from.
         if (state_reg != ST_MEM_WAIT) begin
            ret_sync_next = (state_reg == ST_SYNC_DRAIN);
         end
      end else if (redirect) begin
         // A draining sync sits in ID and is killed by the flush.
         state_next     = ST_RUN;
         drain_cnt_next = 4'd0;
      end else if (eff_state == ST_SYNC_DRAIN) begin
         if (draining) begin
            state_next     = ST_SYNC_DRAIN;
            drain_cnt_next = drain_cnt_reg - 4'd1;
         end else begin
            state_next = ST_RUN;
         end
      end else if (load_use) begin
         state_next = ST_RUN;
      end else if (sync_entry) begin
         state_next     = ST_SYNC_DRAIN;
         drain_cnt_next = DRAIN_LOAD;
      end else begin
         state_next = ST_RUN;
      end
   end

   // Wait counter tracks consecutive wait cycles and saturates; the error
   // flag latches when it first reaches the limit.
   always_comb begin
      wait_cnt_next = '0;
      if (mw) begin
         wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg
                                                    : wait_cnt_reg + 1'b1;
      end
      err_next = err_reg || (mw && (wait_cnt_next == WAIT_MAX));
   end

   always_comb begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(co.pc_stall);
      flush_cnt_next = flush_cnt_reg + CNT_W'(redirect);
   end

   // --------------------------------------------------------------------
   // FSM process 3: outputs (Mealy, priority ordered)
   // --------------------------------------------------------------------
   always_comb begin
      co = CO_NONE;
      if (!rst_n) begin
         co = CO_RESET;
      end else if (mw) begin
         co = CO_MEM_WAIT;
      end else if (redirect) begin
         co = CO_REDIRECT;
      end else if (draining || load_use || sync_entry) begin
         co = CO_HOLD_ID;
      end
   end

   assign pipe.pc_stall      = co.pc_stall;
   assign pipe.if_id_stall   = co.if_id_stall;
   assign pipe.if_id_bubble  = co.if_id_bubble;
   assign pipe.id_ex_stall   = co.id_ex_stall;
   assign pipe.id_ex_bubble  = co.id_ex_bubble;
   assign pipe.ex_mem_stall  = co.ex_mem_stall;
   assign pipe.ex_mem_bubble = co.ex_mem_bubble;
   assign pipe.mem_wb_bubble = co.mem_wb_bubble;

   assign mem_timeout_err = err_reg;
   assign stall_cycles    = stall_cnt_reg;
   assign flush_count     = flush_cnt_reg;
   assign ctrl_state      = state_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Each step drives the pipeline
// inputs, pushes the expected stall/bubble vector and FSM state onto a
// scoreboard queue, and pops/compares it mid-cycle. Counters and the
// timeout flag are checked right after the relevant clock edge.
// Vector bit order: pc_stall, if_id_stall, if_id_bubble, id_ex_stall,
//                   id_ex_bubble, ex_mem_stall, ex_mem_bubble, mem_wb_bubble
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_RST  = 8'b0010_1011;
   localparam logic [7:0] O_MW   = 8'b1101_0101;
   localparam logic [7:0] O_RD   = 8'b0010_1000;
   localparam logic [7:0] O_HOLD = 8'b1100_1000;

   typedef struct {
      string      tag;
      logic [7:0] vec;
      logic [1:0] st;
   } sb_t;

   logic        sys_clk;
   logic        rst_n;
   logic        mem_timeout_err;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   logic [1:0]  ctrl_state;
   logic [7:0]  obs_vec;

   sb_t sb_q[$];
   int  n_cmp  = 0;
   int  n_fail = 0;

   pipeline_hazard_ctrl_if pif ();

   pipeline_hazard_ctrl #(
      .SYNC_DRAIN_CYCLES (3),
      .MEM_TIMEOUT       (8),
      .CNT_W             (32)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .pipe            (pif),
      .mem_timeout_err (mem_timeout_err),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count),
      .ctrl_state      (ctrl_state)
   );

   assign obs_vec = {pif.pc_stall, pif.if_id_stall, pif.if_id_bubble,
                     pif.id_ex_stall, pif.id_ex_bubble, pif.ex_mem_stall,
                     pif.ex_mem_bubble, pif.mem_wb_bubble};

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic idle();
      pif.id_valid      = 1'b0;
      pif.id_rs         = 5'd0;
      pif.id_rt         = 5'd0;
      pif.id_uses_rs    = 1'b0;
      pif.id_uses_rt    = 1'b0;
      pif.id_is_sync    = 1'b0;
      pif.ex_mem_to_reg = 1'b0;
      pif.ex_reg_dst_id = 5'd0;
      pif.ex_redirect   = 1'b0;
      pif.mem_req       = 1'b0;
      pif.mem_ack       = 1'b0;
   endtask

   task automatic set_sync();
      idle();
      pif.id_valid   = 1'b1;
      pif.id_is_sync = 1'b1;
   endtask

   // One clock cycle with the inputs already driven by the caller.
   task automatic cycle(input string tag, input logic [7:0] ev, input logic [1:0] es);
      sb_t e;
      sb_q.push_back('{tag, ev, es});
      @(negedge sys_clk);
      e = sb_q.pop_front();
      n_cmp++;
      assert (obs_vec === e.vec) else begin
         n_fail++;
         $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs_vec, e.vec);
      end
      n_cmp++;
      assert (ctrl_state === e.st) else begin
         n_fail++;
         $error("FAIL %s state: observed %0d expected %0d", e.tag, ctrl_state, e.st);
      end
      $display("[%0t] %s ctrl=%b state=%0d", $time, e.tag, obs_vec, ctrl_state);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("[%0t] %s = %0d", $time, tag, obs);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      @(posedge sys_clk);
      #1;

      // Reset dominates even with a wait and a redirect pending.
      pif.mem_req     = 1'b1;
      pif.ex_redirect = 1'b1;
      cycle("reset_a", O_RST, ST_RUN);
      cycle("reset_b", O_RST, ST_RUN);
      rst_n = 1'b1;
      idle();
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      chk("rst_flush_count", flush_count, 32'd0);
      chk("rst_timeout_err", 32'(mem_timeout_err), 32'd0);
      cycle("idle", O_NONE, ST_RUN);

      // lw $t0 in EX, add reads $t0 via rs: exactly one bubble.
      pif.id_valid = 1'b1; pif.id_rs = 5'd8; pif.id_uses_rs = 1'b1;
      pif.ex_mem_to_reg = 1'b1; pif.ex_reg_dst_id = 5'd8;
      cycle("lu_rs", O_HOLD, ST_RUN);
      pif.ex_mem_to_reg = 1'b0; pif.ex_reg_dst_id = 5'd0;
      cycle("lu_after_bubble", O_NONE, ST_RUN);
      chk("lu_stall_cycles", stall_cycles, 32'd1);

      // Load to $zero is never a hazard.
      pif.id_rs = 5'd0; pif.ex_mem_to_reg = 1'b1; pif.ex_reg_dst_id = 5'd0;
      cycle("lu_zero_dst", O_NONE, ST_RUN);
      // rt matches but is not read.
      pif.id_rs = 5'd3; pif.id_uses_rs = 1'b0; pif.id_rt = 5'd8;
      pif.id_uses_rt = 1'b0; pif.ex_reg_dst_id = 5'd8;
      cycle("lu_rt_unused", O_NONE, ST_RUN);
      // rt matches and is read.
      pif.id_rt = 5'd9; pif.id_uses_rt = 1'b1; pif.ex_reg_dst_id = 5'd9;
      cycle("lu_rt", O_HOLD, ST_RUN);
      // Same match but IF/ID holds no instruction.
      pif.id_valid = 1'b0;
      cycle("lu_id_invalid", O_NONE, ST_RUN);
      chk("lu_rt_stall_cycles", stall_cycles, 32'd2);

      // Single-cycle redirect.
      idle();
      pif.ex_redirect = 1'b1;
      cycle("redirect", O_RD, ST_RUN);
      chk("redirect_flush", flush_count, 32'd1);
      // Redirect wins over a simultaneous load-use.
      pif.id_valid = 1'b1; pif.id_rs = 5'd8; pif.id_uses_rs = 1'b1;
      pif.ex_mem_to_reg = 1'b1; pif.ex_reg_dst_id = 5'd8;
      cycle("redirect_over_lu", O_RD, ST_RUN);
      chk("redirect_lu_flush", flush_count, 32'd2);
      chk("redirect_no_stall", stall_cycles, 32'd2);

      // Five wait cycles with a redirect parked in EX, then ack.
      idle();
      pif.mem_req = 1'b1; pif.ex_redirect = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cycle("mem_wait", O_MW, (i == 1) ? ST_RUN : ST_MEM_WAIT);
      end
      pif.mem_ack = 1'b1;
      cycle("mem_ack_redirect", O_RD, ST_MEM_WAIT);
      idle();
      cycle("mem_done", O_NONE, ST_RUN);
      chk("mw_stall_cycles", stall_cycles, 32'd7);
      chk("mw_flush", flush_count, 32'd3);

      // Plain sync: three hold cycles, then release into EX.
      set_sync();
      cycle("sync_detect", O_HOLD, ST_RUN);
      cycle("sync_drain_1", O_HOLD, ST_SYNC_DRAIN);
      cycle("sync_drain_2", O_HOLD, ST_SYNC_DRAIN);
      cycle("sync_release", O_NONE, ST_SYNC_DRAIN);
      idle();
      cycle("sync_done", O_NONE, ST_RUN);
      chk("sync_stall_cycles", stall_cycles, 32'd10);

      // Sync with a two-cycle wait inside the drain: hold stretches to 5.
      set_sync();
      cycle("sync_mw_detect", O_HOLD, ST_RUN);
      pif.mem_req = 1'b1;
      cycle("sync_mw_wait_1", O_MW, ST_SYNC_DRAIN);
      cycle("sync_mw_wait_2", O_MW, ST_MEM_WAIT);
      pif.mem_req = 1'b0;
      cycle("sync_mw_resume", O_HOLD, ST_MEM_WAIT);
      cycle("sync_mw_drain", O_HOLD, ST_SYNC_DRAIN);
      cycle("sync_mw_release", O_NONE, ST_SYNC_DRAIN);
      idle();
      cycle("sync_mw_done", O_NONE, ST_RUN);
      chk("sync_mw_stall_cycles", stall_cycles, 32'd15);

      // Redirect during drain kills the sync.
      set_sync();
      cycle("sync_rd_detect", O_HOLD, ST_RUN);
      pif.ex_redirect = 1'b1;
      cycle("sync_rd_abort", O_RD, ST_SYNC_DRAIN);
      idle();
      cycle("sync_rd_after", O_NONE, ST_RUN);
      chk("sync_rd_flush", flush_count, 32'd4);
      chk("sync_rd_stall_cycles", stall_cycles, 32'd16);

      // Ack withheld 10 cycles against a limit of 8.
      pif.mem_req = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cycle("timeout_wait", O_MW, (i == 1) ? ST_RUN : ST_MEM_WAIT);
         chk("timeout_err", 32'(mem_timeout_err), (i >= 8) ? 32'd1 : 32'd0);
      end
      pif.mem_ack = 1'b1;
      cycle("timeout_ack", O_NONE, ST_MEM_WAIT);
      idle();
      cycle("timeout_done", O_NONE, ST_RUN);
      chk("timeout_err_sticky", 32'(mem_timeout_err), 32'd1);
      chk("timeout_stall_cycles", stall_cycles, 32'd26);

      // Reset in the middle of a drain clears everything at once.
      set_sync();
      cycle("rst_sync_detect", O_HOLD, ST_RUN);
      rst_n = 1'b0;
      cycle("rst_mid_sync", O_RST, ST_SYNC_DRAIN);
      chk("post_rst_err", 32'(mem_timeout_err), 32'd0);
      chk("post_rst_stall_cycles", stall_cycles, 32'd0);
      chk("post_rst_flush", flush_count, 32'd0);
      chk("post_rst_state", 32'(ctrl_state), 32'd0);
      rst_n = 1'b1;
      idle();
      cycle("post_rst_idle", O_NONE, ST_RUN);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
